// File: rtl/data_store_buffer.sv
// -----------------------------------------------------------------------------
// data_store_buffer
//
// Posted-write store buffer between the memory stage and data_mem. Stores are
// queued without stalling while there is room and drained in order. Each
// drained store is a one-cycle write strobe followed by a wait on mem_clk_stall.
// A load waits for the queue to drain, then issues a one-cycle read strobe.
// The core stays stalled until the read data has been captured. There is no
// forwarding and no reordering.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   core_addr         byte address from the memory stage
//   core_write_data   store data
//   core_memwrite     store request (held while core_stall)
//   core_memread      load request (held while core_stall)
//   core_sign_mask    access size/sign code, passed through unchanged
//   core_read_data    registered load result
//   core_stall        core must hold its request
//   drain_busy        queue non-empty or a memory operation in flight
//   mem_addr          address to data_mem (held for the whole access)
//   mem_write_data    write data to data_mem
//   mem_memwrite      one-cycle write strobe
//   mem_memread       one-cycle read strobe
//   mem_sign_mask     sign mask to data_mem
//   mem_read_data     data_mem read data
//   mem_clk_stall     data_mem busy flag
// -----------------------------------------------------------------------------
module data_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_write_data,
    input  logic        core_memwrite,
    input  logic        core_memread,
    input  logic [3:0]  core_sign_mask,
    output logic [31:0] core_read_data,
    output logic        core_stall,
    output logic        drain_busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_ST,
        WAIT_ST,
        ISSUE_LD,
        WAIT_LD,
        LD_DONE
    } state_t;

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    state_t             state_q;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [PTR_W-1:0]   head_next;

    logic [31:0]        fifo_addr_q [DEPTH];
    logic [31:0]        fifo_data_q [DEPTH];
    logic [3:0]         fifo_mask_q [DEPTH];

    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_write_data_q;
    logic [3:0]         mem_sign_mask_q;
    logic               mem_memwrite_q;
    logic               mem_memread_q;
    logic [31:0]        core_read_data_q;

    logic               enq;
    logic               deq;

    // A load present alongside a store wins, so the store is never queued.
    // A full queue refuses stores even if it is dequeuing this cycle.
    assign enq       = core_memwrite & ~core_memread & (count_q < CNT_FULL);
    assign deq       = (state_q == WAIT_ST) & ~mem_clk_stall;
    assign head_next = head_q + PTR_ONE;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq) begin
            head_d = head_q + PTR_ONE;
        end
        if (enq) begin
            tail_d = tail_q + PTR_ONE;
        end
        if (enq && !deq) begin
            count_d = count_q + CNT_ONE;
        end else if (!enq && deq) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset; count_q decides which entries are valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr_q[tail_q] <= core_addr;
            fifo_data_q[tail_q] <= core_write_data;
            fifo_mask_q[tail_q] <= core_sign_mask;
        end
    end

    // Memory-side FSM. The strobes are registered and set only on entry to
    // an ISSUE state, so they last one cycle and can never be back to back.
    // The address, data and mask stay put from ISSUE through the end of WAIT,
    // because data_mem does not latch them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            mem_addr_q       <= '0;
            mem_write_data_q <= '0;
            mem_sign_mask_q  <= '0;
            mem_memwrite_q   <= 1'b0;
            mem_memread_q    <= 1'b0;
            core_read_data_q <= '0;
        end else begin
            mem_memwrite_q <= 1'b0;
            mem_memread_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        mem_addr_q       <= fifo_addr_q[head_q];
                        mem_write_data_q <= fifo_data_q[head_q];
                        mem_sign_mask_q  <= fifo_mask_q[head_q];
                        mem_memwrite_q   <= 1'b1;
                        state_q          <= ISSUE_ST;
                    end else if (core_memread) begin
                        mem_addr_q      <= core_addr;
                        mem_sign_mask_q <= core_sign_mask;
                        mem_memread_q   <= 1'b1;
                        state_q         <= ISSUE_LD;
                    end
                end
                ISSUE_ST: state_q <= WAIT_ST;
                WAIT_ST: begin
                    if (!mem_clk_stall) begin
                        if (count_q > CNT_ONE) begin
                            mem_addr_q       <= fifo_addr_q[head_next];
                            mem_write_data_q <= fifo_data_q[head_next];
                            mem_sign_mask_q  <= fifo_mask_q[head_next];
                            mem_memwrite_q   <= 1'b1;
                            state_q          <= ISSUE_ST;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                ISSUE_LD: state_q <= WAIT_LD;
                WAIT_LD: begin
                    if (!mem_clk_stall) begin
                        core_read_data_q <= mem_read_data;
                        state_q          <= LD_DONE;
                    end
                end
                LD_DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // A load is released only in LD_DONE, which is when core_read_data is
    // valid.
    assign core_stall = (core_memwrite & ~core_memread & (count_q == CNT_FULL))
                      | (core_memread & (state_q != LD_DONE));

    assign drain_busy     = (count_q != '0) | (state_q != IDLE);
    assign core_read_data = core_read_data_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_sign_mask  = mem_sign_mask_q;
    assign mem_memwrite   = mem_memwrite_q;
    assign mem_memread    = mem_memread_q;

endmodule

// File: tb/tb_data_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_data_store_buffer
//
// Drives data_store_buffer with directed and randomized store/load traffic.
// data_mem is modelled as a word store that raises mem_clk_stall for the one
// cycle after each strobe. Expected results come from a posted-write model:
//   - an associative memory of the last value stored to each address;
//   - a queue of accepted stores in program order;
//   - cycle counts derived from the documented latencies.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_store_buffer;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] core_addr;
    logic [31:0] core_write_data;
    logic        core_memwrite;
    logic        core_memread;
    logic [3:0]  core_sign_mask;
    logic [31:0] core_read_data;
    logic        core_stall;
    logic        drain_busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data;
    logic        mem_clk_stall = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int strobeViolations = 0;
    logic prevStrobe = 1'b0;

    logic [31:0] dmem   [logic [31:0]];
    logic [31:0] expMem [logic [31:0]];
    wr_t         wrLog  [$];
    wr_t         expWr  [$];
    int          rdLog  [$];
    logic [31:0] rdDataQ = '0;

    data_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .core_addr       (core_addr),
        .core_write_data (core_write_data),
        .core_memwrite   (core_memwrite),
        .core_memread    (core_memread),
        .core_sign_mask  (core_sign_mask),
        .core_read_data  (core_read_data),
        .core_stall      (core_stall),
        .drain_busy      (drain_busy),
        .mem_addr        (mem_addr),
        .mem_write_data  (mem_write_data),
        .mem_memwrite    (mem_memwrite),
        .mem_memread     (mem_memread),
        .mem_sign_mask   (mem_sign_mask),
        .mem_read_data   (mem_read_data),
        .mem_clk_stall   (mem_clk_stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memLookup(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] expLookup(input logic [31:0] a);
        return expMem.exists(a) ? expMem[a] : 32'h0;
    endfunction

    // data_mem model: it writes on the strobe edge and captures read data
    // from the held address. It reports busy for exactly one cycle after
    // each strobe.
    always @(posedge clk) begin
        if (mem_memwrite) dmem[mem_addr] = mem_write_data;
    end

    always @(posedge clk) begin
        mem_clk_stall <= mem_memwrite | mem_memread;
        if (mem_memread) rdDataQ <= memLookup(mem_addr);
    end

    assign mem_read_data = rdDataQ;

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_memwrite) begin
            wrLog.push_back('{addr: mem_addr, data: mem_write_data, mask: mem_sign_mask, cyc: cyc});
        end
        if (mem_memread) rdLog.push_back(cyc);
        if (prevStrobe && (mem_memwrite || mem_memread)) strobeViolations++;
        prevStrobe = mem_memwrite | mem_memread;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] m);
        core_memwrite   = wr;
        core_memread    = rd;
        core_addr       = a;
        core_write_data = d;
        core_sign_mask  = m;
    endtask

    task automatic idle();
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Presents a store and holds it until core_stall drops. The request
    // stays on the inputs until the next operation begins.
    task automatic storeOp(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m, output int stalls);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, a, d, m);
        #1;
        stalls = 0;
        while (core_stall === 1'b1 && stalls < 100) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        checkOutput({tag, "_accept"}, {31'h0, core_stall}, 32'h0);
        expWr.push_back('{addr: a, data: d, mask: m, cyc: 0});
        expMem[a] = d;
    endtask

    task automatic loadOp(input string tag, input logic [31:0] a, output logic [31:0] d,
                          output int stalls);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, a, 32'h0, 4'hF);
        #1;
        stalls = 0;
        while (core_stall === 1'b1 && stalls < 200) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        checkOutput({tag, "_release"}, {31'h0, core_stall}, 32'h0);
        d = core_read_data;
    endtask

    task automatic waitDrain(input string tag, output int doneCyc);
        int n = 0;
        while (drain_busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_drained"}, {31'h0, drain_busy}, 32'h0);
        doneCyc = cyc;
    endtask

    task automatic checkWrites(input string tag);
        checkOutput({tag, "_wrCount"}, 32'(wrLog.size()), 32'(expWr.size()));
        for (int i = 0; i < wrLog.size() && i < expWr.size(); i++) begin
            checkOutput($sformatf("%s_wrAddr%0d", tag, i), wrLog[i].addr, expWr[i].addr);
            checkOutput($sformatf("%s_wrData%0d", tag, i), wrLog[i].data, expWr[i].data);
            checkOutput($sformatf("%s_wrMask%0d", tag, i), {28'h0, wrLog[i].mask}, {28'h0, expWr[i].mask});
        end
        wrLog.delete();
        expWr.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          st;
        int          ls;
        int          doneCyc;
        logic [31:0] rd;
        logic [31:0] a;

        // Reset held with a store request asserted: nothing may be queued.
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h1234, 32'h55, 4'hF);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_memwrite",   {31'h0, mem_memwrite}, 32'h0);
        checkOutput("rst_memread",    {31'h0, mem_memread}, 32'h0);
        checkOutput("rst_memAddr",    mem_addr, 32'h0);
        checkOutput("rst_memWdata",   mem_write_data, 32'h0);
        checkOutput("rst_memMask",    {28'h0, mem_sign_mask}, 32'h0);
        checkOutput("rst_readData",   core_read_data, 32'h0);
        checkOutput("rst_drainBusy",  {31'h0, drain_busy}, 32'h0);
        checkOutput("rst_coreStall",  {31'h0, core_stall}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("postRst_drainBusy", {31'h0, drain_busy}, 32'h0);
        checkOutput("postRst_noWrites",  32'(wrLog.size()), 32'h0);

        // Four stores on consecutive cycles, then a fifth while full. The
        // first dequeue completes 4 cycles after the first accept, so the
        // fifth store sees exactly one full cycle.
        for (int i = 0; i < 4; i++) begin
            storeOp($sformatf("fill%0d", i), 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, st);
            checkOutput($sformatf("fill%0d_stalls", i), 32'(st), 32'h0);
        end
        storeOp("full", 32'h1010, 32'hA4, 4'hF, st);
        checkOutput("full_stalls", 32'(st), 32'h1);
        idle();
        waitDrain("fill", doneCyc);
        for (int i = 1; i < wrLog.size(); i++) begin
            checkOutput($sformatf("fill_spacing%0d", i), 32'(wrLog[i].cyc - wrLog[i-1].cyc), 32'h3);
        end
        if (wrLog.size() > 0) begin
            checkOutput("fill_busyDrop", 32'(doneCyc - wrLog[wrLog.size()-1].cyc), 32'h3);
        end
        checkWrites("fill");
        for (int i = 0; i < 5; i++) begin
            a = 32'h1000 + 32'(4 * i);
            loadOp($sformatf("readback%0d", i), a, rd, ls);
            checkOutput($sformatf("readback%0d_data", i), rd, expLookup(a));
            checkOutput($sformatf("readback%0d_stalls", i), 32'(ls), 32'h4);
        end
        idle();

        // Store then immediate load of the same address. The load waits
        // 4 + 3*1 + 1 cycles, and its read strobe comes 4 cycles after the
        // write strobe.
        storeOp("raw_st", 32'h1010, 32'hDEADBEEF, 4'hF, st);
        loadOp("raw_ld", 32'h1010, rd, ls);
        checkOutput("raw_data",   rd, 32'hDEADBEEF);
        checkOutput("raw_stalls", 32'(ls), 32'h8);
        if (wrLog.size() > 0 && rdLog.size() > 0) begin
            checkOutput("raw_order", 32'(rdLog[rdLog.size()-1] - wrLog[wrLog.size()-1].cyc), 32'h4);
        end
        idle();
        waitDrain("raw", doneCyc);
        checkWrites("raw");

        // Byte store: the sign mask must reach data_mem unchanged.
        storeOp("byte", 32'h2000, 32'h5A, 4'b0001, st);
        idle();
        waitDrain("byte", doneCyc);
        checkOutput("byte_led", memLookup(32'h2000), 32'h5A);
        checkOutput("byte_mask", {28'h0, mem_sign_mask}, 32'h1);
        checkWrites("byte");

        // Reset during WAIT_ST with two entries queued. The first write
        // strobe has already reached data_mem, and the second store is lost.
        storeOp("rstA", 32'h3000, 32'h11111111, 4'hF, st);
        storeOp("rstB", 32'h3004, 32'h22222222, 4'hF, st);
        idle();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midRst_drainBusy", {31'h0, drain_busy}, 32'h0);
        checkOutput("midRst_memwrite",  {31'h0, mem_memwrite}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        expWr.pop_back();
        expMem.delete(32'h3004);
        repeat (10) @(negedge clk);
        #1;
        waitDrain("midRst", doneCyc);
        checkWrites("midRst");
        loadOp("midRst_ldA", 32'h3000, rd, ls);
        checkOutput("midRst_ldA_data",   rd, expLookup(32'h3000));
        checkOutput("midRst_ldA_stalls", 32'(ls), 32'h4);
        loadOp("midRst_ldB", 32'h3004, rd, ls);
        checkOutput("midRst_ldB_data",   rd, expLookup(32'h3004));
        idle();

        // Randomized mix of stores, loads and idle gaps over a small address
        // window, checked against the posted-write model.
        for (int i = 0; i < 40; i++) begin
            a = 32'h4000 + 32'(4 * $urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0, 1: storeOp($sformatf("rnd%0d_st", i), a, $urandom, 4'($urandom_range(0, 15)), st);
                2: begin
                    loadOp($sformatf("rnd%0d_ld", i), a, rd, ls);
                    checkOutput($sformatf("rnd%0d_ldData", i), rd, expLookup(a));
                end
                default: idle();
            endcase
        end
        idle();
        waitDrain("rnd", doneCyc);
        checkWrites("rnd");
        for (int i = 0; i < 8; i++) begin
            a = 32'h4000 + 32'(4 * i);
            checkOutput($sformatf("rnd_mem%0d", i), memLookup(a), expLookup(a));
        end

        checkOutput("strobeSpacing", 32'(strobeViolations), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
